// File: rtl/shared_timer_pkg.sv
// Shared definitions for shared_timer_arbiter: FSM state encoding and
// default sizing constants used by the top level and the arbiter.
package shared_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_PRESCALE = 50_000;  // 1 ms per timer unit at 50 MHz

endpackage

// File: rtl/shared_timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker. Scans req upward starting at last+1,
// wrapping past the top index, and reports the first set bit.
module rr_arbiter
  import shared_timer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // First requester after the previous winner wins; last itself is scanned last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/shared_timer_arbiter.sv
// One prescaled countdown timer shared by NUM_REQ requesters through a
// round-robin arbiter. Optional progress output enabled by defining
// SHARED_TIMER_REMAIN_EN (adds port remain).
//
// Handshake: a requester raises req[i] with dur slice i stable and holds it.
// gnt[i] rises one cycle after req is sampled in IDLE and stays high for
// dur*PRESCALE+1 cycles; done[i] then pulses for one cycle with gnt low.
// Dropping req[i] while granted aborts: gnt falls on the next edge and no
// done is produced. dur is captured only at the grant edge.
module shared_timer_arbiter
  import shared_timer_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] dur,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
`ifdef SHARED_TIMER_REMAIN_EN
  ,
  output logic [CNT_W-1:0]         remain
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PW    = $clog2(PRESCALE);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [PW-1:0]    PRE_TOP  = PW'(PRESCALE - 1);

  // state_q is the FSM state; probe it hierarchically when debugging.
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic [IDX_W-1:0]   arb_winner;
  logic               arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req    (req),
    .last   (last_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // Next-state and next-output logic; all outputs come from flops below.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;
    presc_d = presc_q;
    gnt_d   = gnt;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = RUN;
          owner_d = arb_winner;
          last_d  = arb_winner;
          gnt_d   = NUM_REQ'(1) << arb_winner;
          count_d = dur[arb_winner*CNT_W +: CNT_W];
          presc_d = '0;
        end
      end
      RUN: begin
        if (!req[owner_q]) begin
          // Owner withdrew: release silently.
          state_d = IDLE;
          gnt_d   = '0;
        end else if (count_q == '0) begin
          // Zero test comes first so the count can never wrap.
          state_d         = DONE;
          gnt_d           = '0;
          done_d[owner_q] = 1'b1;
        end else if (presc_q == PRE_TOP) begin
          presc_d = '0;
          count_d = count_q - CNT_W'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, timer and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      count_q <= '0;
      presc_q <= '0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
      presc_q <= presc_d;
      gnt     <= gnt_d;
      done    <= done_d;
      busy    <= (state_d != IDLE);
    end
  end

`ifdef SHARED_TIMER_REMAIN_EN
  // Progress view for the owner: live count while running, zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remain <= '0;
    end else begin
      remain <= (state_d == RUN) ? count_d : '0;
    end
  end
`else
  // Without the progress output the count stays internal.
`endif

endmodule
